// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready load and shift strobe
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high; aborts any word in flight
//   data_in       WIDTH-bit parallel word, captured on accept (load_valid & load_ready)
//   load_valid    upstream presents a word on data_in
//   load_ready    a word can be accepted this cycle (combinational from shift_en)
//   shift_en      downstream consumes the current serial bit at this edge
//   serial_out    registered serial bit; IDLE_LEVEL when no word is in flight
//   serial_valid  serial_out carries a data bit
//   last_bit      serial_out carries the final bit of the word
//   busy          a word is in flight (same as serial_valid)
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               serial_q, serial_d;
  logic               accept;
  logic               cnt_zero;
  logic               unused_shreg_end;

  // The bit at the output end of shreg is already on serial_out when it is
  // shifted away, so it is never read on its own.
  assign unused_shreg_end = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  assign cnt_zero     = (cnt_q == '0);
  assign serial_valid = (state_q == SHIFT);
  assign busy         = (state_q == SHIFT);
  assign last_bit     = (state_q == SHIFT) && cnt_zero;
  // The last bit's shift edge doubles as a load edge so back-to-back words
  // need no gap bit; load_valid never feeds load_ready.
  assign load_ready   = (state_q == IDLE) || ((state_q == SHIFT) && cnt_zero && shift_en);
  assign accept       = load_valid && load_ready;
  assign serial_out   = serial_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;

    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = data_in;
      cnt_d    = CNT_W'(WIDTH - 1);
      serial_d = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    end else if ((state_q == SHIFT) && shift_en) begin
      if (!cnt_zero) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (MSB_FIRST) begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          serial_d = shreg_q[WIDTH-2];
        end else begin
          shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
          serial_d = shreg_q[1];
        end
      end else begin
        state_d  = IDLE;
        serial_d = IDLE_LEVEL;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      serial_q <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst [2];
  logic       lv  [2];
  logic       se  [2];
  logic [7:0] din [2];
  logic       so  [2];
  logic       sv  [2];
  logic       lb  [2];
  logic       lr  [2];
  logic       bz  [2];

  int n_vec = 0;
  int n_err = 0;

  // dut 0: WIDTH=4 MSB-first idle 0; dut 1: WIDTH=8 LSB-first idle 1
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clock(clock), .reset(rst[0]), .data_in(din[0][3:0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .shift_en(se[0]), .serial_out(so[0]),
    .serial_valid(sv[0]), .last_bit(lb[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_b (
    .clock(clock), .reset(rst[1]), .data_in(din[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .shift_en(se[1]), .serial_out(so[1]),
    .serial_valid(sv[1]), .last_bit(lb[1]), .busy(bz[1]));

  int cfg_w    [2] = '{4, 8};
  bit cfg_msb  [2] = '{1'b1, 1'b0};
  bit cfg_idle [2] = '{1'b0, 1'b1};

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input int id, input string tag,
                           input logic e_so, input logic e_sv,
                           input logic e_lb, input logic e_lr);
    check({tag, " serial_out"},   so[id], e_so);
    check({tag, " serial_valid"}, sv[id], e_sv);
    check({tag, " busy"},         bz[id], e_sv);
    check({tag, " last_bit"},     lb[id], e_lb);
    check({tag, " load_ready"},   lr[id], e_lr);
  endtask

  typedef struct {
    logic       lv;
    logic [3:0] d;
    logic       se;
    logic       so, sv, lb, lr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic l, input logic [3:0] d, input logic s,
                     input logic eso, input logic esv, input logic elb, input logic elr);
    vec_t v;
    v.lv = l; v.d = d; v.se = s; v.so = eso; v.sv = esv; v.lb = elb; v.lr = elr;
    tbl.push_back(v);
  endtask

  // behavioural reference: word, index of current bit, in-flight flag
  bit         m_busy [2];
  logic [7:0] m_word [2];
  int         m_k    [2];

  initial begin
    logic [3:0] w4;
    logic [7:0] w8;
    logic       pend [2];

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; lv[i] = 1'b0; se[i] = 1'b0; din[i] = '0;
    end
    @(negedge clock);
    #1;
    check_all(0, "reset_a", 1'b0, 1'b0, 1'b0, 1'b1);
    check_all(1, "reset_b", 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // MSB-first continuous: 1011
    add(1, 4'b1011, 1, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 0, 1);
    // gapped shift: 0110, shift_en 1,0,0,1,1,0,1
    add(1, 4'b0110, 0, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 1, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 1, 1);
    add(0, 4'b0000, 0, 0, 0, 0, 1);
    // back-to-back: 1100 then 0011
    add(1, 4'b1100, 1, 0, 0, 0, 1);
    add(1, 4'b0011, 1, 1, 1, 0, 0);
    add(1, 4'b0011, 1, 1, 1, 0, 0);
    add(1, 4'b0011, 1, 0, 1, 0, 0);
    add(1, 4'b0011, 1, 0, 1, 1, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 0, 1);
    // busy-time load pulse of 1111 while 1011 has cnt=2
    add(1, 4'b1011, 1, 0, 0, 0, 1);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(1, 4'b1111, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      @(negedge clock);
      lv[0] = tbl[i].lv; din[0] = {4'b0000, tbl[i].d}; se[0] = tbl[i].se;
      #1;
      check_all(0, $sformatf("row%0d", i), tbl[i].so, tbl[i].sv, tbl[i].lb, tbl[i].lr);
    end

    // async reset mid-frame: 1101, reset after the second bit
    @(negedge clock);
    lv[0] = 1'b1; din[0] = 8'h0D; se[0] = 1'b1;
    #1 check("rst_seq accept ready", lr[0], 1'b1);
    @(negedge clock);
    lv[0] = 1'b0;
    @(negedge clock);
    #1 check_all(0, "rst_seq bit1", 1'b1, 1'b1, 1'b0, 1'b0);
    #1 rst[0] = 1'b1;
    #1 check_all(0, "rst_seq async", 1'b0, 1'b0, 1'b0, 1'b1);
    lv[0] = 1'b1; din[0] = 8'h0F;
    @(negedge clock);
    #1 check_all(0, "rst_seq held", 1'b0, 1'b0, 1'b0, 1'b1);
    rst[0] = 1'b0; din[0] = 8'h09;
    #1 check("rst_seq release ready", lr[0], 1'b1);
    w4 = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      lv[0] = 1'b0;
      #1 check_all(0, $sformatf("rst_seq post bit%0d", k), w4[3-k], 1'b1, (k == 3), (k == 3));
    end
    @(negedge clock);
    #1 check_all(0, "rst_seq post idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // LSB-first, WIDTH=8, idle level 1: A5
    w8 = 8'hA5;
    @(negedge clock);
    lv[1] = 1'b1; din[1] = w8; se[1] = 1'b1;
    #1 check_all(1, "lsb idle before", 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      lv[1] = 1'b0;
      #1 check_all(1, $sformatf("lsb bit%0d", k), w8[k], 1'b1, (k == 7), (k == 7));
    end
    @(negedge clock);
    #1 check_all(1, "lsb idle after", 1'b1, 1'b0, 1'b0, 1'b1);

    // randomized traffic on both instances against the reference model
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; lv[i] = 1'b0; se[i] = 1'b0;
      m_busy[i] = 1'b0; m_word[i] = '0; m_k[i] = 0; pend[i] = 1'b0;
    end
    @(negedge clock);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 63) == 0);
        if (!pend[i]) begin
          lv[i]  = ($urandom_range(0, 2) != 0);
          din[i] = 8'($urandom);
          if (cfg_w[i] == 4) din[i][7:4] = 4'b0000;
        end
        se[i] = ($urandom_range(0, 9) < 7);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        int   w;
        logic e_so, e_lb, e_lr, acc;
        w = cfg_w[i];
        if (rst[i]) m_busy[i] = 1'b0;
        e_so = m_busy[i] ? m_word[i][cfg_msb[i] ? (w - 1 - m_k[i]) : m_k[i]] : cfg_idle[i];
        e_lb = m_busy[i] && (m_k[i] == w - 1);
        e_lr = !m_busy[i] || ((m_k[i] == w - 1) && se[i]);
        check_all(i, $sformatf("rand%0d c%0d", i, cyc), e_so, m_busy[i], e_lb, e_lr);
        acc = !rst[i] && lv[i] && e_lr;
        if (acc) begin
          m_busy[i] = 1'b1; m_word[i] = din[i]; m_k[i] = 0;
        end else if (!rst[i] && m_busy[i] && se[i]) begin
          if (m_k[i] == w - 1) m_busy[i] = 1'b0;
          else m_k[i] = m_k[i] + 1;
        end
        pend[i] = lv[i] && !acc;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
